// File: rtl/ascon_pack.sv
// Shared Ascon types, round-count constants and sequencer state encoding.
package ascon_pack;

    typedef logic [0:4][63:0] type_state;

    localparam logic [3:0] P12_FIRST  = 4'd0;
    localparam logic [3:0] P6_FIRST   = 4'd6;
    localparam logic [3:0] LAST_ROUND = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Round constant for round i of p12: high nibble counts down from f, low nibble counts up.
    function automatic logic [7:0] round_constant(input logic [3:0] round);
        return {4'hf - round, round};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/permutation_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box layer, linear diffusion layer.
module permutation_round
    import ascon_pack::*;
(
    input  type_state  state,
    input  logic [3:0] round,
    output type_state  result
);

    logic [63:0] x2_pc;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;
    logic [63:0] d0, d1, d2, d3, d4;

    assign x2_pc = state[2] ^ {56'd0, round_constant(round)};

    // Substitution layer in bitsliced form: input mixing, chi-like core, output mixing.
    assign b0 = state[0] ^ state[4];
    assign b1 = state[1];
    assign b2 = x2_pc ^ state[1];
    assign b3 = state[3];
    assign b4 = state[4] ^ state[3];

    assign c0 = b0 ^ (~b1 & b2);
    assign c1 = b1 ^ (~b2 & b3);
    assign c2 = b2 ^ (~b3 & b4);
    assign c3 = b3 ^ (~b4 & b0);
    assign c4 = b4 ^ (~b0 & b1);

    assign d0 = c0 ^ c4;
    assign d1 = c1 ^ c0;
    assign d2 = ~c2;
    assign d3 = c3 ^ c2;
    assign d4 = c4;

    assign result[0] = d0 ^ rotr(d0, 19) ^ rotr(d0, 28);
    assign result[1] = d1 ^ rotr(d1, 61) ^ rotr(d1, 39);
    assign result[2] = d2 ^ rotr(d2, 1)  ^ rotr(d2, 6);
    assign result[3] = d3 ^ rotr(d3, 10) ^ rotr(d3, 17);
    assign result[4] = d4 ^ rotr(d4, 7)  ^ rotr(d4, 41);

endmodule

// File: rtl/permutation_seq.sv
// Iterative Ascon p12/p6 sequencer, one round per clock, result held until acknowledged.
// Define PERM_SEQ_ABORT_EN to add an abort_i port that cancels a run or a pending result.
module permutation_seq
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  type_state  state_i,
    input  logic       ack_i,
`ifdef PERM_SEQ_ABORT_EN
    input  logic       abort_i,
`endif
    output logic       ready_o,
    output logic       valid_o,
    output type_state  state_o,
    output logic [3:0] round_o
);

    fsm_state_t fsm_q, fsm_d;
    type_state  data_q, data_d;
    type_state  round_result;
    logic [3:0] count_q, count_d;

    permutation_round u_round (
        .state  (data_q),
        .round  (count_q),
        .result (round_result)
    );

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q   <= IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // The counter is cleared when the last round lands so it never steps past LAST_ROUND.
    always_comb begin
        fsm_d   = fsm_q;
        data_d  = data_q;
        count_d = count_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        round_o = 4'd0;

        case (fsm_q)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    data_d  = state_i;
                    count_d = mode_i ? P6_FIRST : P12_FIRST;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                round_o = count_q;
                data_d  = round_result;
                if (count_q >= LAST_ROUND) begin
                    count_d = 4'd0;
                    fsm_d   = DONE;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ack_i) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d   = IDLE;
                count_d = 4'd0;
            end
        endcase

`ifdef PERM_SEQ_ABORT_EN
        if (abort_i && (fsm_q != IDLE)) begin
            fsm_d   = IDLE;
            data_d  = data_q;
            count_d = 4'd0;
        end
`endif
    end

    assign state_o = data_q;

endmodule
